// File: rtl/jtopl_slot_seq_if.sv
// Sequencer bus: clock enable and hold request in, operator timing and hold ack out.
// master = host/register side, slave = the sequencer itself.
interface jtopl_slot_seq_if;
    logic        cen;
    logic        hold_req;
    logic        hold_ack;
    logic        cenop;
    logic [17:0] slot;
    logic [1:0]  group;
    logic [2:0]  subslot;
    logic        zero;

    modport master (
        output cen, hold_req,
        input  hold_ack, cenop, slot, group, subslot, zero
    );

    modport slave (
        input  cen, hold_req,
        output hold_ack, cenop, slot, group, subslot, zero
    );
endinterface

// File: rtl/jtopl_slot_seq.sv
// OPL operator timing: divides cen into cenop, walks an 18-slot one-hot ring, freezes at a sample boundary on request.
// cenop registered 1 clk after the DIV-th cen; hold_ack rises on the edge that retires slot 17 while draining.
module jtopl_slot_seq #(
    parameter int DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    jtopl_slot_seq_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HELD} state_t;

    localparam logic [3:0] PRE_LAST = 4'(DIV - 1);

    state_t      state;
    logic        hold_ack;
    logic [3:0]  pre;
    logic        cenop_i;
    logic        cenop;
    logic [17:0] slot;
    logic [1:0]  grp;
    logic [2:0]  sub;

    assign cenop = cenop_i & (state != HELD);

    assign bus.cenop    = cenop;
    assign bus.zero     = cenop & slot[0];
    assign bus.hold_ack = hold_ack;
    assign bus.slot     = slot;
    assign bus.group    = grp;
    assign bus.subslot  = sub;

    // Free-running prescaler: keeps its phase even while held, so a release
    // does not realign cenop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre     <= 4'd0;
            cenop_i <= 1'b0;
        end else if (bus.cen) begin
            if (pre == PRE_LAST) begin
                pre     <= 4'd0;
                cenop_i <= 1'b1;
            end else begin
                pre     <= pre + 4'd1;
                cenop_i <= 1'b0;
            end
        end else begin
            cenop_i <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= 18'd1;
            grp  <= 2'd0;
            sub  <= 3'd0;
        end else if (cenop) begin
            slot <= {slot[16:0], slot[17]};
            if (sub == 3'd5) begin
                sub <= 3'd0;
                grp <= (grp == 2'd2) ? 2'd0 : grp + 2'd1;
            end else begin
                sub <= sub + 3'd1;
            end
        end
    end

    // The slot-17 pulse that triggers HELD is still emitted, so the freeze
    // lands exactly with slot back at bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            hold_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.hold_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.hold_req) begin
                        state <= RUN;
                    end else if (cenop && slot[17]) begin
                        state    <= HELD;
                        hold_ack <= 1'b1;
                    end
                end
                HELD: begin
                    if (!bus.hold_req) begin
                        state    <= RUN;
                        hold_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    hold_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/jtopl_slot_seq.md
Name: jtopl_slot_seq

Overview:
Timing sequencer for the OPL operator pipeline. It divides the master clock enable into the per-slot operator enable `cenop` and walks an 18-bit one-hot `slot` ring in lock-step with it. It also provides group/sub-slot indices and a sample-start strobe. A hold/ack handshake lets the register or host side freeze the whole operator datapath (LFO, envelope, phase) cleanly at a sample boundary.

Parameters:
DIV, 4, clk-enable cycles (cen=1 cycles) per cenop pulse; legal range 1..16.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
cen  input  1  master clock enable
hold_req  input  1  request to freeze the operator datapath at the next sample boundary
hold_ack  output  1  high while the datapath is frozen
cenop  output  1  one-clk operator enable pulse; gated off while held
slot  output  18  one-hot current slot; bit n = slot n
group  output  2  slot / 6, range 0..2
subslot  output  3  slot % 6, range 0..5
zero  output  1  sample-start strobe: cenop & slot[0]

Behaviour:
- Reset (rst_n=0 at a clk edge) applies on that edge regardless of state:
  - pre=0, cenop_i=0, slot=18'd1, group=0, subslot=0, state=RUN.
  - Outputs cenop=0, zero=0, hold_ack=0.
- Prescaler (4-bit pre), evaluated every clk:
  - If cen=1 and pre==DIV-1: pre<=0, cenop_i<=1.
  - Else if cen=1: pre<=pre+1, cenop_i<=0.
  - If cen=0: pre holds, cenop_i<=0.
  - cenop_i is therefore never wider than 1 clk. With DIV=1, cenop_i equals cen delayed by one clk.
  - The prescaler keeps running in every state, including HELD.
- Output gating: cenop = cenop_i & (state!=HELD). zero = cenop & slot[0]. Both are combinational from registers.
- Slot advance on every clk with cenop=1:
  - slot rotates left; slot[17] wraps to slot[0].
  - subslot increments and wraps 5->0. group increments when subslot wraps, and wraps 2->0.
  - Invariant: slot == 1<<(group*6+subslot) at all times.
  - A full sample is 18 cenop pulses, i.e. 18*DIV cen cycles.
- Hold FSM (registered state: RUN, DRAIN, HELD):
  - RUN: hold_req=1 -> DRAIN on the next edge.
  - DRAIN, hold_req=0: -> RUN with no ack; the sequence is uninterrupted.
  - DRAIN, hold_req=1, and the edge carries a cenop with slot[17]=1: -> HELD. That slot-17 pulse is emitted normally and slot becomes bit 0.
  - HELD: hold_ack=1 (registered, equal to state==HELD). cenop and zero are forced to 0, and slot/group/subslot are frozen at 0.
  - HELD, hold_req=0: -> RUN on the next edge; hold_ack falls on that same edge. The first cenop after release processes slot 0.
  - hold_req rising on the very clk that carries slot[17]'s cenop: the FSM is still in RUN on that edge, so it enters DRAIN afterwards and the freeze occurs at the end of the following sample.
- Latency:
  - hold_req rise to hold_ack: at most 1 + 18*DIV cen cycles plus 1 clk.
  - hold_req fall to hold_ack fall: 1 clk.
- While HELD, a pending cenop_i pulse is dropped, not deferred. The phase of cenop after release follows the free-running prescaler.

Test Plan:
- Reset then cen=1, DIV=4, hold_req=0:
  - first cenop on the 4th clk after rst_n rises, then every 4 clks;
  - slot walks bit0..bit17 and wraps;
  - (group,subslot) reads (0,0)..(2,5);
  - zero pulses every 72 clks;
  - invariant holds on every clk.
- cen toggling 1/0 each clk, DIV=4 -> cenop every 8 clks, always 1 clk wide; slot advances only on cenop.
- hold_req=1 asserted while slot=bit5:
  - cenops continue through slot 17, then slot=bit0 and hold_ack=1;
  - no cenop/zero for 100 held clks, slot stays bit0;
  - drop hold_req -> hold_ack=0 next clk; the next cenop has zero=1 and slot advances to bit1 after it.
- hold_req pulsed for 10 clks at slot 3 (released before slot 17) -> hold_ack never rises; cenop cadence and slot sequence unchanged.
- rst_n=0 for one clk while HELD, hold_req=0 -> hold_ack=0, slot=bit0, group=0, subslot=0; first cenop DIV clks after release.
- DIV=1, cen random -> cenop equals cen delayed 1 clk; 18 cen pulses complete exactly one slot revolution.
